// File: rtl/parity_engine_if.sv
// Bus between the UART TX/RX state machines and the parity engine.
// The master side drives frame configuration and data; the slave side returns parity status.
interface parity_engine_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = $clog2(DATA_WIDTH + 1)
);
    logic                  parity_en;
    logic [1:0]            parity_mode;
    logic [LEN_WIDTH-1:0]  data_len;
    logic                  data_valid;
    logic                  busy;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  parity_bit;
    logic                  parity_ready;
    logic                  rx_start;
    logic                  rx_bit_valid;
    logic                  rx_bit_in;
    logic                  rx_active;
    logic                  parity_err;
    logic                  err_valid;

    modport master (
        output parity_en, parity_mode, data_len, data_valid, busy, data_in,
        output rx_start, rx_bit_valid, rx_bit_in,
        input  parity_bit, parity_ready, rx_active, parity_err, err_valid
    );

    modport slave (
        input  parity_en, parity_mode, data_len, data_valid, busy, data_in,
        input  rx_start, rx_bit_valid, rx_bit_in,
        output parity_bit, parity_ready, rx_active, parity_err, err_valid
    );
endinterface

// File: rtl/parity_engine.sv
// UART parity engine: one-cycle TX parity generation from a parallel word and a
// bit-serial RX parity checker, both honouring runtime data length and mark/space modes.
module parity_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    parity_engine_if.slave   bus
);

    typedef enum logic [1:0] {
        RX_IDLE     = 2'b00,
        RX_ACCUM    = 2'b01,
        RX_WAIT_PAR = 2'b10
    } rx_state_e;

    // Lengths of zero or beyond the datapath width mean a full-width frame.
    function automatic logic [LEN_WIDTH-1:0] clamp_len(input logic [LEN_WIDTH-1:0] len);
        logic [LEN_WIDTH-1:0] eff;
        if ((len == {LEN_WIDTH{1'b0}}) || (len > LEN_WIDTH'(DATA_WIDTH))) begin
            eff = LEN_WIDTH'(DATA_WIDTH);
        end else begin
            eff = len;
        end
        return eff;
    endfunction

    function automatic logic masked_xor(input logic [DATA_WIDTH-1:0] data,
                                        input logic [LEN_WIDTH-1:0]  len);
        logic p;
        p = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            p = p ^ (data[i] & (LEN_WIDTH'(i) < len));
        end
        return p;
    endfunction

    function automatic logic mode_parity(input logic [1:0] mode, input logic acc);
        logic p;
        case (mode)
            2'b00:   p = acc;
            2'b01:   p = ~acc;
            2'b10:   p = 1'b1;
            default: p = 1'b0;
        endcase
        return p;
    endfunction

    logic                 tx_capture_s;
    logic                 parity_bit_q,   parity_bit_d;
    logic                 parity_ready_q, parity_ready_d;

    rx_state_e            state_q, state_d;
    logic [1:0]           mode_q,  mode_d;
    logic [LEN_WIDTH-1:0] len_q,   len_d;
    logic [LEN_WIDTH-1:0] cnt_q,   cnt_d;
    logic                 acc_q,   acc_d;
    logic                 err_q,   err_d;
    logic                 err_valid_q, err_valid_d;

    // TX parity next state: update on capture, otherwise hold.
    always_comb begin
        tx_capture_s   = bus.parity_en & bus.data_valid & ~bus.busy;
        parity_bit_d   = parity_bit_q;
        parity_ready_d = tx_capture_s;
        if (tx_capture_s) begin
            parity_bit_d = mode_parity(bus.parity_mode,
                                       masked_xor(bus.data_in, clamp_len(bus.data_len)));
        end else begin
            parity_bit_d = parity_bit_q;
        end
    end

    // RX checker next state; bits arriving alongside rx_start belong to no frame.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        err_d       = err_q;
        err_valid_d = 1'b0;
        if ((state_q != RX_IDLE) && bus.rx_start) begin
            state_d = RX_ACCUM;
            mode_d  = bus.parity_mode;
            len_d   = clamp_len(bus.data_len);
            cnt_d   = {LEN_WIDTH{1'b0}};
            acc_d   = 1'b0;
        end else begin
            case (state_q)
                RX_IDLE: begin
                    if (bus.rx_start && bus.parity_en) begin
                        state_d = RX_ACCUM;
                        mode_d  = bus.parity_mode;
                        len_d   = clamp_len(bus.data_len);
                        cnt_d   = {LEN_WIDTH{1'b0}};
                        acc_d   = 1'b0;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end
                RX_ACCUM: begin
                    if (bus.rx_bit_valid) begin
                        acc_d = acc_q ^ bus.rx_bit_in;
                        cnt_d = cnt_q + LEN_WIDTH'(1);
                        if ((cnt_q + LEN_WIDTH'(1)) == len_q) begin
                            state_d = RX_WAIT_PAR;
                        end else begin
                            state_d = RX_ACCUM;
                        end
                    end else begin
                        state_d = RX_ACCUM;
                    end
                end
                RX_WAIT_PAR: begin
                    if (bus.rx_bit_valid) begin
                        err_d       = bus.rx_bit_in ^ mode_parity(mode_q, acc_q);
                        err_valid_d = 1'b1;
                        state_d     = RX_IDLE;
                    end else begin
                        state_d = RX_WAIT_PAR;
                    end
                end
                default: begin
                    state_d = RX_IDLE;
                end
            endcase
        end
    end

    // State registers for both paths.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_bit_q   <= 1'b0;
            parity_ready_q <= 1'b0;
            state_q        <= RX_IDLE;
            mode_q         <= 2'b00;
            len_q          <= {LEN_WIDTH{1'b0}};
            cnt_q          <= {LEN_WIDTH{1'b0}};
            acc_q          <= 1'b0;
            err_q          <= 1'b0;
            err_valid_q    <= 1'b0;
        end else begin
            parity_bit_q   <= parity_bit_d;
            parity_ready_q <= parity_ready_d;
            state_q        <= state_d;
            mode_q         <= mode_d;
            len_q          <= len_d;
            cnt_q          <= cnt_d;
            acc_q          <= acc_d;
            err_q          <= err_d;
            err_valid_q    <= err_valid_d;
        end
    end

    assign bus.parity_bit   = parity_bit_q;
    assign bus.parity_ready = parity_ready_q;
    assign bus.rx_active    = (state_q != RX_IDLE);
    assign bus.parity_err   = err_q;
    assign bus.err_valid    = err_valid_q;

endmodule
